// File: rtl/retire_trace_buffer.sv
// retire_trace_buffer: passive capture of every instruction retiring from
// MEM/WB into a first-word-fall-through FIFO, drained over a valid/ready port.
// Also keeps retire/drop counters and a sticky halt flag.
//
// Handshake: the head entry transfers on a rising edge where trace_valid and
// trace_ready are both high. trace_valid depends only on registered state, so
// it never depends combinationally on trace_ready. The fields are stable
// while trace_valid is high and trace_ready is low.
module retire_trace_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             trace_en,
  input  logic             wb_valid,
  input  logic [31:0]      wb_instr,
  input  logic [4:0]       wb_rd,
  input  logic             wb_regwrite,
  input  logic [31:0]      wb_data,
  input  logic             wb_halt,
  output logic             trace_valid,
  input  logic             trace_ready,
  output logic [31:0]      trace_instr,
  output logic [4:0]       trace_rd,
  output logic             trace_we,
  output logic [31:0]      trace_data,
  output logic [CNT_W-1:0] retire_count,
  output logic [15:0]      drop_count,
  output logic             halted,
  output logic             done
);

  localparam int AW = $clog2(DEPTH);

  // The pointers carry one extra wrap bit so that full and empty can be
  // told apart without a separate occupancy counter.
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;

  logic [31:0]  instr_mem [DEPTH];
  logic [4:0]   rd_mem    [DEPTH];
  logic         we_mem    [DEPTH];
  logic [31:0]  data_mem  [DEPTH];

  logic         cap;
  logic         entry_we;
  logic         empty;
  logic         full;
  logic         pop;
  logic         push;
  logic         drop;

  // Capture, handshake and FIFO status decode.
  always_comb begin
    cap      = wb_valid & trace_en & ~halted;
    entry_we = wb_regwrite & (wb_rd != 5'd0);
    empty    = (wr_ptr == rd_ptr);
    full     = (wr_ptr[AW] != rd_ptr[AW]) &&
               (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    pop      = ~empty & trace_ready;
    // When full, a pop in the same cycle frees the slot being written.
    push     = cap & (~full | pop);
    drop     = cap & full & ~pop;
  end

  // Entry storage. It needs no reset because the outputs are masked when
  // the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr[AW-1:0]] <= wb_instr;
      rd_mem[wr_ptr[AW-1:0]]    <= entry_we ? wb_rd : 5'd0;
      we_mem[wr_ptr[AW-1:0]]    <= entry_we;
      data_mem[wr_ptr[AW-1:0]]  <= entry_we ? wb_data : 32'd0;
    end
  end

  // Pointers, counters and the sticky halt flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      retire_count <= '0;
      drop_count   <= '0;
      halted       <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr       <= wr_ptr + 1'b1;
        retire_count <= retire_count + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (drop && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (cap && wb_halt) begin
        halted <= 1'b1;
      end
    end
  end

  // Head entry presented straight from storage, zeroed when there is none.
  always_comb begin
    trace_valid = ~empty;
    trace_instr = empty ? 32'd0 : instr_mem[rd_ptr[AW-1:0]];
    trace_rd    = empty ? 5'd0  : rd_mem[rd_ptr[AW-1:0]];
    trace_we    = empty ? 1'b0  : we_mem[rd_ptr[AW-1:0]];
    trace_data  = empty ? 32'd0 : data_mem[rd_ptr[AW-1:0]];
    done        = halted & empty;
  end

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: directed scenarios plus randomized traffic,
// checked against a queue-based model of the trace FIFO.
module tb_retire_trace_buffer;

  localparam int DEPTH = 8;
  localparam int CNT_W = 32;

  logic             clk;
  logic             rst_n;
  logic             trace_en;
  logic             wb_valid;
  logic [31:0]      wb_instr;
  logic [4:0]       wb_rd;
  logic             wb_regwrite;
  logic [31:0]      wb_data;
  logic             wb_halt;
  logic             trace_valid;
  logic             trace_ready;
  logic [31:0]      trace_instr;
  logic [4:0]       trace_rd;
  logic             trace_we;
  logic [31:0]      trace_data;
  logic [CNT_W-1:0] retire_count;
  logic [15:0]      drop_count;
  logic             halted;
  logic             done;

  retire_trace_buffer #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .wb_valid(wb_valid),
    .wb_instr(wb_instr), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .wb_data(wb_data), .wb_halt(wb_halt), .trace_valid(trace_valid),
    .trace_ready(trace_ready), .trace_instr(trace_instr), .trace_rd(trace_rd),
    .trace_we(trace_we), .trace_data(trace_data), .retire_count(retire_count),
    .drop_count(drop_count), .halted(halted), .done(done)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: entry = {instr[69:38], rd[37:33], we[32], data[31:0]}.
  logic [69:0]      exp_q[$];
  logic [CNT_W-1:0] m_retire;
  logic [15:0]      m_drop;
  logic             m_halted;

  function automatic logic [69:0] exp_head();
    return (exp_q.size() > 0) ? exp_q[0] : 70'd0;
  endfunction

  // Advance one clock edge, updating the model from the inputs seen there.
  task automatic tick();
    logic c, p, w;
    int sz;
    logic [69:0] e;
    sz = exp_q.size();
    c  = wb_valid && trace_en && !m_halted;
    p  = (sz > 0) && trace_ready;
    w  = wb_regwrite && (wb_rd != 5'd0);
    e  = {wb_instr, (w ? wb_rd : 5'd0), w, (w ? wb_data : 32'd0)};
    @(posedge clk);
    if (p) void'(exp_q.pop_front());
    if (c) begin
      if (sz < DEPTH || p) begin
        exp_q.push_back(e);
        m_retire = m_retire + 1;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
      if (wb_halt) m_halted = 1'b1;
    end
    #1;
  endtask

  task automatic drive_wb(input logic v, input logic [31:0] ins, input logic [4:0] rd,
                          input logic rw, input logic [31:0] dat, input logic h);
    wb_valid = v; wb_instr = ins; wb_rd = rd; wb_regwrite = rw; wb_data = dat; wb_halt = h;
  endtask

  task automatic drive_random_wb(input logic v);
    drive_wb(v, $urandom, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, 1'b0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; trace_en = 1'b1; trace_ready = 1'b0;
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    exp_q.delete(); m_retire = '0; m_drop = '0; m_halted = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", trace_valid); end
    n_checks++; if ({trace_instr, trace_rd, trace_we, trace_data} !== 70'd0) begin n_fail++; $display("FAIL reset_fields: got %0h want 0", {trace_instr, trace_rd, trace_we, trace_data}); end
    n_checks++; if (retire_count !== '0) begin n_fail++; $display("FAIL reset_retire: got %0d want 0", retire_count); end
    n_checks++; if (drop_count !== 16'd0) begin n_fail++; $display("FAIL reset_drop: got %0d want 0", drop_count); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted: got %0b want 0", halted); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %0b want 0", done); end
  endtask

  task automatic test_basic_order();
    logic [31:0] ins [3];
    logic [4:0]  rds [3];
    logic [31:0] dat [3];
    ins[0] = 32'h00500093; rds[0] = 5'd1; dat[0] = 32'd5;
    ins[1] = 32'h00A00113; rds[1] = 5'd2; dat[1] = 32'd10;
    ins[2] = 32'h002081B3; rds[2] = 5'd3; dat[2] = 32'd15;
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_wb(1'b1, ins[i], rds[i], 1'b1, dat[i], 1'b0);
      tick();
      n_checks++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid[%0d]: got %0b want 1", i, trace_valid); end
      n_checks++;
      if ({trace_instr, trace_rd, trace_we, trace_data} !== {ins[i], rds[i], 1'b1, dat[i]}) begin
        n_fail++;
        $display("FAIL basic_entry[%0d]: got %h/%0d/%0b/%0d want %h/%0d/1/%0d", i,
                 trace_instr, trace_rd, trace_we, trace_data, ins[i], rds[i], dat[i]);
      end
    end
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    tick();
    n_checks++; if (retire_count !== 32'd3) begin n_fail++; $display("FAIL basic_retire: got %0d want 3", retire_count); end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL basic_drained: got %0b want 0", trace_valid); end
  endtask

  task automatic test_x0_write();
    trace_ready = 1'b0;
    drive_wb(1'b1, 32'h00000013, 5'd0, 1'b1, 32'h1234, 1'b0);
    tick();
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    n_checks++; if (trace_valid !== 1'b1) begin n_fail++; $display("FAIL x0_valid: got %0b want 1", trace_valid); end
    n_checks++;
    if ({trace_we, trace_rd, trace_data} !== 38'd0) begin
      n_fail++;
      $display("FAIL x0_fields: got we=%0b rd=%0d data=%h want 0/0/0", trace_we, trace_rd, trace_data);
    end
    trace_ready = 1'b1;
    tick();
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL x0_drained: got %0b want 0", trace_valid); end
  endtask

  task automatic test_overflow();
    logic [CNT_W-1:0] r0;
    logic [15:0] d0;
    r0 = m_retire; d0 = m_drop;
    trace_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      drive_random_wb(1'b1);
      tick();
    end
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    n_checks++; if (drop_count !== d0 + 16'd2) begin n_fail++; $display("FAIL ovf_drop: got %0d want %0d", drop_count, d0 + 16'd2); end
    n_checks++; if (retire_count !== r0 + 8) begin n_fail++; $display("FAIL ovf_retire: got %0d want %0d", retire_count, r0 + 8); end
    trace_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({trace_instr, trace_rd, trace_we, trace_data} !== exp_head() || trace_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL ovf_drain[%0d]: got %h want %h", i, {trace_instr, trace_rd, trace_we, trace_data}, exp_head());
      end
      tick();
    end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_empty: got %0b want 0", trace_valid); end
  endtask

  task automatic test_full_push_pop();
    logic [15:0] d0;
    logic [31:0] last_instr;
    d0 = m_drop;
    trace_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive_random_wb(1'b1);
      tick();
    end
    last_instr = 32'hCAFE0001;
    trace_ready = 1'b1;
    drive_wb(1'b1, last_instr, 5'd7, 1'b1, 32'h77, 1'b0);
    tick();
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    n_checks++; if (drop_count !== d0) begin n_fail++; $display("FAIL fpp_drop: got %0d want %0d", drop_count, d0); end
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({trace_instr, trace_rd, trace_we, trace_data} !== exp_head() || trace_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL fpp_drain[%0d]: got %h want %h", i, {trace_instr, trace_rd, trace_we, trace_data}, exp_head());
      end
      if (i == 7) begin
        n_checks++; if (trace_instr !== last_instr) begin n_fail++; $display("FAIL fpp_last: got %h want %h", trace_instr, last_instr); end
      end
      tick();
    end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL fpp_empty: got %0b want 0", trace_valid); end
  endtask

  task automatic test_random();
    int guard;
    for (int i = 0; i < 400; i++) begin
      trace_en    = ($urandom_range(0, 9) != 0);
      trace_ready = 1'($urandom_range(0, 1));
      drive_random_wb($urandom_range(0, 9) < 7);
      tick();
      n_checks++;
      if (trace_valid !== (exp_q.size() > 0) ||
          {trace_instr, trace_rd, trace_we, trace_data} !== exp_head() ||
          retire_count !== m_retire || drop_count !== m_drop || done !== 1'b0) begin
        n_fail++;
        $display("FAIL rand[%0d]: got v=%0b e=%h r=%0d d=%0d done=%0b want v=%0b e=%h r=%0d d=%0d done=0",
                 i, trace_valid, {trace_instr, trace_rd, trace_we, trace_data}, retire_count,
                 drop_count, done, exp_q.size() > 0, exp_head(), m_retire, m_drop);
      end
    end
    trace_en = 1'b1; trace_ready = 1'b1;
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    guard = 0;
    while (exp_q.size() > 0 && guard < 20) begin tick(); guard++; end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL rand_drain: got %0b want 0", trace_valid); end
  endtask

  task automatic test_halt();
    logic [CNT_W-1:0] r0;
    r0 = m_retire;
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) drive_wb(1'b1, 32'h00000073, 5'd0, 1'b0, 32'd0, 1'b1);
      else        drive_random_wb(1'b1);
      tick();
    end
    n_checks++; if (halted !== 1'b1) begin n_fail++; $display("FAIL halt_flag: got %0b want 1", halted); end
    n_checks++; if (retire_count !== r0 + 3) begin n_fail++; $display("FAIL halt_retire: got %0d want %0d", retire_count, r0 + 3); end
    trace_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL halt_done_early[%0d]: got %0b want 0", i, done); end
      n_checks++;
      if ({trace_instr, trace_rd, trace_we, trace_data} !== exp_head()) begin
        n_fail++;
        $display("FAIL halt_drain[%0d]: got %h want %h", i, {trace_instr, trace_rd, trace_we, trace_data}, exp_head());
      end
      if (i == 2) begin
        n_checks++; if (trace_instr !== 32'h00000073) begin n_fail++; $display("FAIL halt_last: got %h want 00000073", trace_instr); end
      end
      drive_random_wb(1'b1);
      tick();
    end
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL halt_done: got %0b want 1", done); end
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL halt_empty: got %0b want 0", trace_valid); end
    n_checks++; if (retire_count !== r0 + 3) begin n_fail++; $display("FAIL halt_nocap: got %0d want %0d", retire_count, r0 + 3); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ins;
    do_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive_random_wb(1'b1);
      tick();
    end
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    #2 rst_n = 1'b0;
    exp_q.delete(); m_retire = '0; m_drop = '0; m_halted = 1'b0;
    #1;
    n_checks++; if (trace_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %0b want 0", trace_valid); end
    n_checks++; if (retire_count !== '0) begin n_fail++; $display("FAIL rstmid_retire: got %0d want 0", retire_count); end
    n_checks++; if (halted !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rstmid_halt: got %0b/%0b want 0/0", halted, done); end
    #2 rst_n = 1'b1;
    tick();
    ins = $urandom;
    drive_wb(1'b1, ins, 5'd9, 1'b1, 32'h99, 1'b0);
    tick();
    drive_wb(1'b0, 32'd0, 5'd0, 1'b0, 32'd0, 1'b0);
    n_checks++;
    if (trace_valid !== 1'b1 || {trace_instr, trace_rd, trace_we, trace_data} !== {ins, 5'd9, 1'b1, 32'h99}) begin
      n_fail++;
      $display("FAIL rstmid_capture: got v=%0b %h want v=1 %h", trace_valid,
               {trace_instr, trace_rd, trace_we, trace_data}, {ins, 5'd9, 1'b1, 32'h99});
    end
    n_checks++; if (retire_count !== 32'd1) begin n_fail++; $display("FAIL rstmid_count: got %0d want 1", retire_count); end
  endtask

  initial begin
    test_reset();
    test_basic_order();
    test_x0_write();
    test_overflow();
    test_full_push_pop();
    test_random();
    test_halt();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
